// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipeline.
// Word width, PC step, NOP/HALT encodings, fetch state, IF/ID bundle.
package cpu_pkg;

  localparam int WORD_W  = 16;
  localparam int PC_STEP = 2;

  localparam logic [WORD_W-1:0] NOP_INSTR = '0;
  localparam logic [3:0]        OPC_HALT  = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc_plus2;
    logic              valid;
  } if_id_t;

  function automatic logic [3:0] opcode(
    input logic [WORD_W-1:0] i
  );
    return i[WORD_W-1:WORD_W-4];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus.
// master: drives pc_out, takes instr_in; slave: the memory side.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic [WORD_W-1:0] pc_out;
  logic [WORD_W-1:0] instr_in;

  modport master (
    output pc_out,
    input  instr_in
  );

  modport slave (
    input  pc_out,
    output instr_in
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load/hold/flush.
// Ports: clk, rst (async low), load, flush, d in, q out.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t ifid_q;
  if_id_t ifid_d;

  // Flush leaves pc_plus2 alone; only the
  // instruction and valid bit mark a bubble.
  always_comb begin
    ifid_d = ifid_q;
    if (flush) begin
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
    end else if (load) begin
      ifid_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_q.instr    <= NOP_INSTR;
      ifid_q.pc_plus2 <= '0;
      ifid_q.valid    <= 1'b0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign q = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, HALT FSM, fetch counter, IF/ID register.
// Ports: clk, rst (async low), imem bus, stall, branch, IF/ID outs, status.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int          AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  fetch_stage_if.master     imem,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [AW-1:0]     branch_target,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc_plus2,
  output logic              ifid_valid,
  output logic              halted,
  output logic [WORD_W-1:0] fetch_count
);

  logic [AW-1:0]     pc_q, pc_d, pc_inc;
  fetch_state_e      st_q, st_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic              load, flush;
  logic              halt_drain, run_go;
  if_id_t            ifid_in, ifid_out;

  assign pc_inc = pc_q + AW'(PC_STEP);

  assign halt_drain = !branch_taken
                    && st_q == ST_HALT
                    && !stall;
  assign run_go     = !branch_taken
                    && st_q == ST_RUN
                    && !stall;

  always_comb begin
    pc_d  = pc_q;
    st_d  = st_q;
    cnt_d = cnt_q;
    load  = 1'b0;
    flush = 1'b0;
    unique case (1'b1)
      branch_taken: begin
        pc_d  = {branch_target[AW-1:1], 1'b0};
        flush = 1'b1;
        st_d  = ST_RUN;
      end
      halt_drain: flush = 1'b1;
      run_go: begin
        load  = 1'b1;
        cnt_d = cnt_q + WORD_W'(1);
        // HALT is latched but PC parks on it.
        if (opcode(imem.instr_in) == OPC_HALT)
          st_d = ST_HALT;
        else
          pc_d = pc_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_PC;
      st_q  <= ST_RUN;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign ifid_in.instr    = imem.instr_in;
  assign ifid_in.pc_plus2 = WORD_W'(pc_inc);
  assign ifid_in.valid    = 1'b1;

  if_id_reg u_ifid (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .flush (flush),
    .d     (ifid_in),
    .q     (ifid_out)
  );

  assign imem.pc_out   = WORD_W'(pc_q);
  assign ifid_instr    = ifid_out.instr;
  assign ifid_pc_plus2 = ifid_out.pc_plus2;
  assign ifid_valid    = ifid_out.valid;
  assign halted        = (st_q == ST_HALT);
  assign fetch_count   = cnt_q;

endmodule
